temp_div_stage: RTL and testbench

TEMP_DIV_STAGE -- requirements
Module: temp_div_stage

---
 rtl/temp_pkg.sv | 18 +
 rtl/temp_div_stage_if.sv | 24 ++
 rtl/temp_div_step.sv | 27 ++
 rtl/temp_div_stage.sv | 117 +++++++++++
 tb/tb_temp_div_stage.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/temp_pkg.sv
// Shared types and defaults for the temperature divide stage.
// The divider FSM states live here so the top and any monitors agree on them.
package temp_pkg;

  localparam int unsigned DIVISOR_DEF = 9;
  localparam int unsigned DATA_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  function automatic bit divisor_ok(input int unsigned d);
    return (d >= 1) && (d <= 255);
  endfunction

endpackage

// File: rtl/temp_div_stage_if.sv
// Valid/ready handshake bundle for the divide stage: dividend in, quotient/remainder out.
interface temp_div_stage_if #(
  parameter int unsigned DATA_W = temp_pkg::DATA_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_quot;
  logic [DATA_W-1:0] out_rem;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_quot, out_rem
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_quot, out_rem
  );

endinterface

// File: rtl/temp_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract
// the constant divisor, keep the difference when it does not go negative.
module temp_div_step
  import temp_pkg::*;
#(
  parameter int unsigned DIVISOR = DIVISOR_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic [DATA_W:0] rem_i,
  input  logic            bit_i,
  output logic [DATA_W:0] rem_o,
  output logic            qbit_o
);

  // The shifted value carries one guard bit so the compare is exact for every divisor.
  localparam bit              DIV_FITS = ((DIVISOR >> (DATA_W + 2)) == 0);
  localparam logic [DATA_W+1:0] DIV_V  = (DATA_W + 2)'(DIVISOR);

  logic [DATA_W+1:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    qbit_o  = DIV_FITS && (shifted >= DIV_V);
    rem_o   = qbit_o ? (DATA_W + 1)'(shifted - DIV_V) : shifted[DATA_W:0];
  end

endmodule

// File: rtl/temp_div_stage.sv
// Constant-divisor restoring divider stage: accepts one dividend, spends DATA_W cycles
// producing quotient bits MSB first, then holds the result until downstream takes it.
module temp_div_stage
  import temp_pkg::*;
#(
  parameter int unsigned DIVISOR = DIVISOR_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  temp_div_stage_if.slave  bus
);

  if (!divisor_ok(DIVISOR)) begin : g_bad_divisor
    $error("temp_div_stage: DIVISOR %0d outside 1..255", DIVISOR);
  end

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] out_quot_q, out_quot_d;
  logic [DATA_W-1:0] out_rem_q, out_rem_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W:0]   step_rem;
  logic              step_qbit;
  logic [DATA_W:0]   quot_shift;

  temp_div_step #(
    .DIVISOR (DIVISOR),
    .DATA_W  (DATA_W)
  ) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[DATA_W-1]),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  assign quot_shift = {quot_q, step_qbit};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    quot_d      = quot_q;
    out_quot_d  = out_quot_q;
    out_rem_d   = out_rem_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          dvd_d   = bus.in_data;
          rem_d   = '0;
          quot_d  = '0;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        rem_d  = step_rem;
        dvd_d  = dvd_q << 1;
        quot_d = quot_shift[DATA_W-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          cnt_d       = '0;
          out_quot_d  = quot_shift[DATA_W-1:0];
          out_rem_d   = step_rem[DATA_W-1:0];
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      quot_q      <= '0;
      out_quot_q  <= '0;
      out_rem_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      quot_q      <= quot_d;
      out_quot_q  <= out_quot_d;
      out_rem_q   <= out_rem_d;
      out_valid_q <= out_valid_d;
    end
  end

  // rst gates in_ready directly so it stays low while reset is held in IDLE.
  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_quot  = out_quot_q;
  assign bus.out_rem   = out_rem_q;

endmodule

// File: tb/tb_temp_div_stage.sv
// Self-checking bench for temp_div_stage at DIVISOR=9, DATA_W=8.
module tb_temp_div_stage;

  localparam int unsigned DIV = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  temp_div_stage_if #(.DATA_W(8)) bus ();

  temp_div_stage #(
    .DIVISOR (DIV),
    .DATA_W  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    int unsigned q;
    int unsigned r;
    int unsigned hold;
  } vec_t;

  vec_t vecs [8];

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, fixed latency, optional stall, handshake back to IDLE.
  task automatic run_op(input logic [7:0] d, input int unsigned eq, input int unsigned er,
                        input int unsigned hold, input string tag);
    int unsigned k;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = (hold == 0);
    check({tag, " in_ready before accept"}, bus.in_ready, 1);
    cyc();
    bus.in_valid = 1'b0;
    k = 1;
    while (!bus.out_valid && k < 30) begin
      check({tag, " in_ready busy"}, bus.in_ready, 0);
      bus.in_data = 8'($urandom);
      cyc();
      k++;
    end
    check({tag, " latency"}, k, 9);
    check({tag, " in_ready done"}, bus.in_ready, 0);
    check({tag, " quot"}, bus.out_quot, eq);
    check({tag, " rem"}, bus.out_rem, er);
    for (int unsigned h = 0; h < hold; h++) begin
      cyc();
      check({tag, " stall valid"}, bus.out_valid, 1);
      check({tag, " stall quot"}, bus.out_quot, eq);
      check({tag, " stall rem"}, bus.out_rem, er);
    end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check({tag, " valid after handshake"}, bus.out_valid, 0);
    check({tag, " in_ready after handshake"}, bus.in_ready, 1);
    check({tag, " quot held"}, bus.out_quot, eq);
    check({tag, " rem held"}, bus.out_rem, er);
  endtask

  task automatic busy_input_ignored();
    int unsigned k;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'd100;
    bus.out_ready = 1'b0;
    cyc();
    k = 1;
    while (!bus.out_valid && k < 30) begin
      bus.in_data = 8'($urandom);
      cyc();
      k++;
    end
    check("ign latency", k, 9);
    check("ign quot", bus.out_quot, 100 / DIV);
    check("ign rem", bus.out_rem, 100 % DIV);
    bus.in_data = 8'd45;
    cyc();
    check("ign no accept in done", bus.in_ready, 0);
    check("ign still valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("ign idle after handshake", bus.in_ready, 1);
    check("ign valid low", bus.out_valid, 0);
    cyc();
    bus.in_valid = 1'b0;
    check("ign second accepted", bus.in_ready, 0);
    k = 1;
    while (!bus.out_valid && k < 30) begin
      cyc();
      k++;
    end
    check("ign second latency", k, 9);
    check("ign second quot", bus.out_quot, 45 / DIV);
    check("ign second rem", bus.out_rem, 45 % DIV);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
  endtask

  task automatic reset_mid_op();
    int unsigned seen;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'd200;
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    repeat (4) cyc();
    rst = 1'b1;
    #1;
    check("rst in_ready during reset", bus.in_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    check("rst in_ready after release", bus.in_ready, 1);
    check("rst valid", bus.out_valid, 0);
    check("rst quot zero", bus.out_quot, 0);
    check("rst rem zero", bus.out_rem, 0);
    seen = 0;
    for (int unsigned c = 0; c < 20; c++) begin
      cyc();
      if (bus.out_valid) seen++;
    end
    check("rst discarded op never valid", seen, 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic back_to_back();
    logic [7:0]  ops [3];
    int unsigned exp_q [$];
    int unsigned exp_r [$];
    int unsigned acc [$];
    int unsigned idx, got;
    ops = '{8'd45, 8'd255, 8'd0};
    idx = 0;
    got = 0;
    bus.out_ready = 1'b1;
    for (int unsigned c = 0; c < 80 && got < 3; c++) begin
      if (bus.out_valid && exp_q.size() > 0) begin
        check("b2b quot", bus.out_quot, exp_q.pop_front());
        check("b2b rem", bus.out_rem, exp_r.pop_front());
        got++;
      end
      if (idx < 3) begin
        bus.in_valid = 1'b1;
        bus.in_data  = ops[idx];
        if (bus.in_ready) begin
          exp_q.push_back(ops[idx] / DIV);
          exp_r.push_back(ops[idx] % DIV);
          acc.push_back(c);
          idx++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b results", got, 3);
    check("b2b accepts", acc.size(), 3);
    if (acc.size() == 3) begin
      check("b2b spacing 1", acc[1] - acc[0], 10);
      check("b2b spacing 2", acc[2] - acc[1], 10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned x;
    logic [7:0]  d;

    vecs[0] = '{din: 8'd45,  q: 5,  r: 0, hold: 0};
    vecs[1] = '{din: 8'd255, q: 28, r: 3, hold: 0};
    vecs[2] = '{din: 8'd0,   q: 0,  r: 0, hold: 1};
    vecs[3] = '{din: 8'd100, q: 11, r: 1, hold: 5};
    vecs[4] = '{din: 8'd8,   q: 0,  r: 8, hold: 0};
    vecs[5] = '{din: 8'd9,   q: 1,  r: 0, hold: 2};
    vecs[6] = '{din: 8'd17,  q: 1,  r: 8, hold: 0};
    vecs[7] = '{din: 8'd128, q: 14, r: 2, hold: 3};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    rst = 1'b1;
    repeat (3) cyc();
    check("reset in_ready", bus.in_ready, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset quot", bus.out_quot, 0);
    check("reset rem", bus.out_rem, 0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", bus.in_ready, 1);

    for (int unsigned i = 0; i < 8; i++)
      run_op(vecs[i].din, vecs[i].q, vecs[i].r, vecs[i].hold, $sformatf("vec%0d", i));

    busy_input_ignored();
    reset_mid_op();
    back_to_back();

    // Upstream produces 5*(x-32) mod 256, including wrapped values for x<32.
    for (int unsigned i = 0; i < 40; i++) begin
      x = $urandom_range(0, 255);
      d = 8'((5 * (int'(x) - 32)) & 255);
      run_op(d, d / DIV, d % DIV, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
